// File: rtl/load_store_unit_pkg.sv
// Shared types and defaults for the byte-serial load/store unit.
// Holds the FSM state encoding and the default bus geometry.
package lsu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int BYTES_DEF  = 8;
    localparam int CNT_W      = $clog2(BYTES_DEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Byte-wide data memory bus with a valid/ready beat handshake.
// The LSU is the master; the memory is the slave.
interface load_store_unit_if #(
    parameter int ADDR_W = lsu_pkg::ADDR_W_DEF
);

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_byte_assembler.sv
// Load lane register file plus the store byte select mux.
// word_o already includes the byte being written this cycle.
module lsu_byte_assembler
    import lsu_pkg::*;
#(
    parameter int BYTES = BYTES_DEF,
    parameter int CW    = $clog2(BYTES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               lane_we_i,
    input  logic [CW-1:0]      idx_i,
    input  logic [7:0]         rbyte_i,
    input  logic [8*BYTES-1:0] wword_i,
    output logic [7:0]         wbyte_o,
    output logic [8*BYTES-1:0] word_o
);

    logic [BYTES-1:0][7:0] lane_q;
    logic [BYTES-1:0][7:0] wlanes;
    logic [BYTES-1:0][7:0] word_d;

    assign wlanes  = wword_i;
    assign wbyte_o = wlanes[idx_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
        end else if (lane_we_i) begin
            lane_q[idx_i] <= rbyte_i;
        end
    end

    // Bypass lets the final beat land in the result in the same edge.
    always_comb begin
        word_d = lane_q;
        if (lane_we_i) begin
            word_d[idx_i] = rbyte_i;
        end
    end

    assign word_o = word_d;

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: serializes 64-bit LDUR/STUR into byte beats,
// stalls the core for the access, and rejects illegal requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYTES  = BYTES_DEF
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] DataWrite,
    output logic [63:0] DataRead,
    output logic        stall,
    output logic        done,
    output logic        err,
    load_store_unit_if.master bus
);

    localparam int CW = $clog2(BYTES);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rdata_q;
    logic              we_q;
    logic              err_q;

    logic              req;
    logic              legal;
    logic              beat;
    logic              lane_we;
    logic [7:0]        wbyte;
    logic [63:0]       word_nxt;

    assign req     = MemRead | MemWrite;
    assign legal   = (MemRead ^ MemWrite) &&
                     ((Address >> ADDR_W) == 64'd0);
    assign beat    = (state_q == S_XFER) && bus.mem_ready;
    assign lane_we = beat && !we_q;

    lsu_byte_assembler #(
        .BYTES (BYTES)
    ) u_asm (
        .clk_i     (clk),
        .rst_ni    (Reset),
        .lane_we_i (lane_we),
        .idx_i     (cnt_q),
        .rbyte_i   (bus.mem_rdata),
        .wword_i   (wdata_q),
        .wbyte_o   (wbyte),
        .word_o    (word_nxt)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req) state_d = legal ? S_XFER : S_DONE;
            S_XFER: if (beat && cnt_q == LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset gates stall so the core is released while Reset is low.
    always_comb begin
        stall         = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            S_IDLE: stall = Reset & req;
            S_XFER: begin
                stall         = 1'b1;
                bus.mem_valid = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = base_q + ADDR_W'(cnt_q);
                bus.mem_wdata = wbyte;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req) begin
                we_q    <= MemWrite;
                base_q  <= Address[ADDR_W-1:0];
                wdata_q <= DataWrite;
                cnt_q   <= '0;
                err_q   <= !legal;
            end
            if (beat) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == LAST && !we_q) begin
                    rdata_q <= word_nxt;
                end
            end
        end
    end

    assign DataRead = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 256-byte memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Address;
    logic [63:0] DataWrite;
    logic [63:0] DataRead;
    logic        stall;
    logic        done;
    logic        err;

    logic        rdy;
    logic        init_mem;
    logic [7:0]  mem [256];

    int checks   = 0;
    int failures = 0;

    int          done_cyc;
    int          stall_cnt;
    int          nbeats;
    int          valid_cnt;
    int          hold_bad;
    logic        err_seen;
    logic [63:0] rd_done;
    logic [7:0]  b_addr [16];
    logic [7:0]  b_wd   [16];

    load_store_unit_if #(.ADDR_W(8)) bus ();

    load_store_unit #(
        .ADDR_W (8),
        .BYTES  (8)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .DataWrite (DataWrite),
        .DataRead  (DataRead),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_ready = rdy;
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (bus.mem_valid && bus.mem_ready && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Runs one access from an IDLE cycle; results land in module variables.
    task automatic access(input logic rd, input logic wr,
                          input logic [63:0] a, input logic [63:0] d,
                          input int hold_beat, input int hold_len);
        int   waited;
        logic was_waiting;
        logic [7:0] prev_addr;
        waited = 0;
        was_waiting = 1'b0;
        prev_addr = 8'h00;
        done_cyc = -1;
        stall_cnt = 0;
        nbeats = 0;
        valid_cnt = 0;
        hold_bad = 0;
        err_seen = 1'b0;
        rd_done = '0;
        MemRead = rd;
        MemWrite = wr;
        Address = a;
        DataWrite = d;
        for (int k = 0; k < 40 && done_cyc < 0; k++) begin
            rdy = !(nbeats == hold_beat && waited < hold_len);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus.mem_valid) begin
                valid_cnt++;
                if (was_waiting && bus.mem_addr != prev_addr) hold_bad++;
                was_waiting = !rdy;
                prev_addr = bus.mem_addr;
                if (!rdy) begin
                    waited++;
                end else begin
                    if (nbeats < 16) begin
                        b_addr[nbeats] = bus.mem_addr;
                        b_wd[nbeats] = bus.mem_wdata;
                    end
                    nbeats++;
                end
            end else begin
                was_waiting = 1'b0;
            end
            if (done) begin
                done_cyc = k;
                err_seen = err;
                rd_done = DataRead;
            end
            @(posedge clk);
            #1;
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
        rdy = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        Address = '0;
        DataWrite = '0;
        rdy = 1'b1;
        init_mem = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, done, err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000", {stall, done, err});
        end
        checks++;
        if ({bus.mem_valid, bus.mem_we} !== 2'b00) begin
            failures++;
            $display("FAIL reset_bus got=%b exp=00", {bus.mem_valid, bus.mem_we});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0000", {bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if (DataRead !== 64'h0) begin
            failures++;
            $display("FAIL reset_dataread got=%h exp=0", DataRead);
        end
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        Reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        logic [63:0] wv;
        wv = 64'h1122334455667788;
        access(1'b0, 1'b1, 64'h10, wv, -1, 0);
        checks++;
        if (done_cyc !== 9 || err_seen !== 1'b0) begin
            failures++;
            $display("FAIL store_done got=%0d/%b exp=9/0", done_cyc, err_seen);
        end
        checks++;
        if (stall_cnt !== 9 || nbeats !== 8) begin
            failures++;
            $display("FAIL store_stall got=%0d/%0d exp=9/8", stall_cnt, nbeats);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (b_addr[i] !== 8'(8'h10 + i) || b_wd[i] !== wv[8*i +: 8]) begin
                failures++;
                $display("FAIL store_beat%0d got=%h/%h exp=%h/%h",
                         i, b_addr[i], b_wd[i], 8'(8'h10 + i), wv[8*i +: 8]);
            end
        end
        checks++;
        if (mem[8'h17] !== 8'h11 || mem[8'h10] !== 8'h88) begin
            failures++;
            $display("FAIL store_mem got=%h/%h exp=11/88", mem[8'h17], mem[8'h10]);
        end
        access(1'b1, 1'b0, 64'h10, 64'h0, -1, 0);
        checks++;
        if (done_cyc !== 9 || stall_cnt !== 9 || err_seen !== 1'b0) begin
            failures++;
            $display("FAIL load_timing got=%0d/%0d/%b exp=9/9/0",
                     done_cyc, stall_cnt, err_seen);
        end
        checks++;
        if (rd_done !== 64'h1122334455667788) begin
            failures++;
            $display("FAIL load_data got=%h exp=1122334455667788", rd_done);
        end
        @(negedge clk);
        checks++;
        if (DataRead !== 64'h1122334455667788) begin
            failures++;
            $display("FAIL load_hold got=%h exp=1122334455667788", DataRead);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        access(1'b1, 1'b0, 64'h10, 64'h0, 2, 3);
        checks++;
        if (done_cyc !== 12 || valid_cnt !== 11) begin
            failures++;
            $display("FAIL bp_timing got=%0d/%0d exp=12/11", done_cyc, valid_cnt);
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++;
            $display("FAIL bp_hold got=%0d exp=0", hold_bad);
        end
        checks++;
        if (b_addr[2] !== 8'h12 || b_addr[3] !== 8'h13) begin
            failures++;
            $display("FAIL bp_addr got=%h/%h exp=12/13", b_addr[2], b_addr[3]);
        end
        checks++;
        if (rd_done !== 64'h1122334455667788) begin
            failures++;
            $display("FAIL bp_data got=%h exp=1122334455667788", rd_done);
        end
    endtask

    task automatic test_wrap();
        access(1'b1, 1'b0, 64'hFC, 64'h0, -1, 0);
        checks++;
        if (b_addr[0] !== 8'hFC || b_addr[3] !== 8'hFF ||
            b_addr[4] !== 8'h00 || b_addr[7] !== 8'h03) begin
            failures++;
            $display("FAIL wrap_addr got=%h,%h,%h,%h exp=fc,ff,00,03",
                     b_addr[0], b_addr[3], b_addr[4], b_addr[7]);
        end
        checks++;
        if (rd_done !== 64'h59585B5AA5A4A7A6 || done_cyc !== 9) begin
            failures++;
            $display("FAIL wrap_data got=%h/%0d exp=59585b5aa5a4a7a6/9",
                     rd_done, done_cyc);
        end
    endtask

    task automatic test_illegal();
        access(1'b1, 1'b1, 64'h10, 64'hFFFF, -1, 0);
        checks++;
        if (done_cyc !== 1 || err_seen !== 1'b1 || valid_cnt !== 0) begin
            failures++;
            $display("FAIL ill_both got=%0d/%b/%0d exp=1/1/0",
                     done_cyc, err_seen, valid_cnt);
        end
        checks++;
        if (rd_done !== 64'h59585B5AA5A4A7A6 || stall_cnt !== 1) begin
            failures++;
            $display("FAIL ill_both_data got=%h/%0d exp=59585b5aa5a4a7a6/1",
                     rd_done, stall_cnt);
        end
        access(1'b1, 1'b0, 64'h100, 64'h0, -1, 0);
        checks++;
        if (done_cyc !== 1 || err_seen !== 1'b1 || valid_cnt !== 0) begin
            failures++;
            $display("FAIL ill_range got=%0d/%b/%0d exp=1/1/0",
                     done_cyc, err_seen, valid_cnt);
        end
        checks++;
        if (rd_done !== 64'h59585B5AA5A4A7A6) begin
            failures++;
            $display("FAIL ill_range_data got=%h exp=59585b5aa5a4a7a6", rd_done);
        end
    endtask

    task automatic test_reset_mid();
        MemWrite = 1'b1;
        Address = 64'h40;
        DataWrite = 64'hCAFEBABEDEADBEEF;
        rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 8'h44) begin
            failures++;
            $display("FAIL rst_mid_pre got=%b/%h exp=1/44", bus.mem_valid, bus.mem_addr);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async got=%b%b%b exp=000",
                     bus.mem_valid, stall, done);
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bus.mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle got=%b%b exp=00", stall, bus.mem_valid);
        end
        checks++;
        if (mem[8'h43] !== 8'hDE || mem[8'h44] !== 8'h1E) begin
            failures++;
            $display("FAIL rst_mid_mem got=%h/%h exp=de/1e", mem[8'h43], mem[8'h44]);
        end
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 64'h40, 64'h0, -1, 0);
        checks++;
        if (done_cyc !== 9 || rd_done !== 64'h1D1C1F1EDEADBEEF) begin
            failures++;
            $display("FAIL rst_mid_load got=%0d/%h exp=9/1d1c1f1edeadbeef",
                     done_cyc, rd_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] vbits;
        logic [19:0] dbits;
        logic [19:0] sbits;
        logic [63:0] rd_a;
        logic [63:0] rd_b;
        logic [7:0]  first_b;
        vbits = '0;
        dbits = '0;
        sbits = '0;
        rd_a = '0;
        rd_b = '0;
        first_b = 8'h00;
        MemRead = 1'b1;
        Address = 64'h10;
        rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) Address = 64'h80;
            if (k == 10) Address = 64'h20;
            @(negedge clk);
            vbits[k] = bus.mem_valid;
            dbits[k] = done;
            sbits[k] = stall;
            if (k == 9) rd_a = DataRead;
            if (k == 11) first_b = bus.mem_addr;
            if (k == 19) rd_b = DataRead;
            @(posedge clk);
            #1;
        end
        MemRead = 1'b0;
        checks++;
        if (dbits !== 20'h80200) begin
            failures++;
            $display("FAIL b2b_done got=%h exp=80200", dbits);
        end
        checks++;
        if (vbits !== 20'h7F9FE) begin
            failures++;
            $display("FAIL b2b_valid got=%h exp=7f9fe", vbits);
        end
        checks++;
        if (sbits[9] !== 1'b0 || sbits[10] !== 1'b1 || first_b !== 8'h20) begin
            failures++;
            $display("FAIL b2b_start got=%b%b/%h exp=01/20", sbits[9], sbits[10], first_b);
        end
        checks++;
        if (rd_a !== 64'h1122334455667788 || rd_b !== 64'h7D7C7F7E79787B7A) begin
            failures++;
            $display("FAIL b2b_data got=%h/%h exp=1122334455667788/7d7c7f7e79787b7a",
                     rd_a, rd_b);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory-access stage between the execute datapath (ALU result = address, register read-data 2 = store data) and a byte-wide data memory bus.
- Serializes each 64-bit LDUR/STUR into BYTES single-byte bus beats using a valid/ready handshake.
- Assembles load data, stalls the processor for the duration of the access, and flags out-of-range or illegal requests.

Parameters:
- ADDR_W, 8, byte-address width of the data memory bus (memory holds 2^ADDR_W bytes)
- BYTES, 8, beats per access (64-bit word / 8-bit bus)

Ports:
- clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- MemRead  in  1  load request, held by the processor until done
- MemWrite  in  1  store request, held by the processor until done
- Address  in  64  byte address from ALU result
- DataWrite  in  64  store data
- DataRead  out  64  load result, valid in the done cycle and held until the next load completes
- stall  out  1  processor must not advance PC or write the register file
- done  out  1  one-cycle pulse marking access completion
- err  out  1  qualifies done: access rejected, no bus beats issued
- mem_valid  out  1  bus beat request
- mem_ready  in  1  bus beat accept
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  8  beat write byte
- mem_rdata  in  8  beat read byte, sampled when mem_valid & mem_ready

Behaviour:
- Reset (async, Reset=0): state IDLE; all outputs 0, including DataRead and mem_*. mem_valid drops immediately; a beat in flight is abandoned. Memory contents are not touched.
- States: IDLE, XFER, DONE.
- IDLE, no request (MemRead=MemWrite=0): outputs idle, stall=0.
- IDLE, legal request (exactly one of MemRead/MemWrite, and Address[63:ADDR_W]==0):
  - stall=1 combinationally in the same cycle.
  - At the clock edge, latch op, Address[ADDR_W-1:0], and DataWrite; set count=0; go to XFER.
- IDLE, illegal request (both MemRead and MemWrite, or address out of range):
  - stall=1; next state DONE with err=1; zero bus beats.
  - DataRead unchanged.
- XFER:
  - mem_valid=1, stall=1, mem_addr = base + count (mod 2^ADDR_W, so it wraps at the top of memory).
  - mem_we = latched op.
  - mem_wdata = latched data byte [8*count+7 : 8*count] (little-endian).
  - On mem_valid & mem_ready: for a load, capture mem_rdata into byte lane count; count increments.
  - Beat count == BYTES-1 accepted: go to DONE.
  - mem_ready=0: address and data held stable and mem_valid stays high (no retraction).
- DONE: done=1 for one cycle; stall=0 so the processor advances at this edge. For a load, DataRead is updated with the assembled word by this cycle. Next state IDLE.
- Back-to-back: a request present in IDLE the cycle after DONE is treated as a new access.
- Latency with mem_ready tied high, for legal requests:
  - Request cycle T accepted.
  - Beats occur in cycles T+1..T+8.
  - done is asserted in cycle T+9.
  - stall is high for cycles T..T+8.
- Request inputs are ignored outside IDLE. Changes to Address/DataWrite mid-access have no effect.
- Unaligned addresses are legal. No alignment fault.

Decomposition:
- Package lsu_pkg: state encoding (IDLE/XFER/DONE), default BYTES/ADDR_W constants, beat-count width = clog2(BYTES).
- One natural sub-module, lsu_byte_assembler:
  - BYTES x 8 lane register with a write-enable per lane index, plus the store-byte select mux.
  - Kept separate from the FSM and counter in the top level.

Test Plan:
- Store then load, mem_ready=1: STUR Address=0x10, DataWrite=0x1122334455667788. Expect beats addr 0x10..0x17 with wdata 88,77,...,11; done at T+9, err=0. Then LDUR at 0x10 returns DataRead=0x1122334455667788, stall high exactly 9 cycles.
- Backpressure: mem_ready low 3 cycles on beat 2 of a load. Expect mem_addr/mem_valid held, done at T+12, correct data.
- Wrap-around: load at Address=0xFC. Expect beats 0xFC,0xFD,0xFE,0xFF,0x00..0x03, bytes assembled in that order.
- Illegal requests: MemRead=MemWrite=1 -> done&err at T+1, no mem_valid, DataRead unchanged. Address=0x100 -> same response.
- Reset mid-access: drop Reset during beat 4 of a store. Expect mem_valid=0 and stall=0 immediately (async), state IDLE after release, and a following load completes normally.
- Back-to-back: load held high across DONE. Expect the second access to start the cycle after done, with no overlap of beats.
